// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares one single-port data memory between two requesters. The memory
//   reads combinationally and writes on the rising CLK edge.
//   Port 0 is the core load/store unit; port 1 is the loader/debug master.
//   A round-robin arbiter grants one access per cycle. The grant is
//   combinational, and read data is returned registered one cycle later.
//
// Ports
//   CLK, RST              clock, asynchronous active-high reset
//   REQx/WEx/Ax/WDx       requester x access request, write enable, address, write data
//   GNTx                  requester x granted this cycle (combinational)
//   RVALIDx/RDATAx        requester x registered read response (1-cycle pulse)
//   MEM_A/MEM_WE/MEM_WD   drive to the memory instance
//   MEM_RD                combinational read data from the memory
module data_mem_arbiter #(
  parameter int WIDTH     = 32,
  parameter int WIDTH_ADR = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ0,
  input  logic                 WE0,
  input  logic [WIDTH_ADR-1:0] A0,
  input  logic [WIDTH-1:0]     WD0,
  output logic                 GNT0,
  output logic                 RVALID0,
  output logic [WIDTH-1:0]     RDATA0,
  input  logic                 REQ1,
  input  logic                 WE1,
  input  logic [WIDTH_ADR-1:0] A1,
  input  logic [WIDTH-1:0]     WD1,
  output logic                 GNT1,
  output logic                 RVALID1,
  output logic [WIDTH-1:0]     RDATA1,
  output logic [WIDTH_ADR-1:0] MEM_A,
  output logic                 MEM_WE,
  output logic [WIDTH-1:0]     MEM_WD,
  input  logic [WIDTH-1:0]     MEM_RD
);

  // Round-robin pointer: index of the port preferred on contention.
  logic prio;
  logic gnt0;
  logic gnt1;
  logic rd0;
  logic rd1;

  always_comb begin
    gnt0 = REQ0 && (!REQ1 || !prio);
    gnt1 = REQ1 && (!REQ0 ||  prio);
  end

  // With no grant, the bus idles on port 0's address and data, and writes stay off.
  always_comb begin
    MEM_A  = gnt1 ? A1  : A0;
    MEM_WD = gnt1 ? WD1 : WD0;
    MEM_WE = (gnt0 && WE0 && REQ0) || (gnt1 && WE1 && REQ1);
  end

  assign GNT0 = gnt0;
  assign GNT1 = gnt1;
  assign rd0  = gnt0 && !WE0;
  assign rd1  = gnt1 && !WE1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prio    <= 1'b0;
      RVALID0 <= 1'b0;
      RVALID1 <= 1'b0;
      RDATA0  <= '0;
      RDATA1  <= '0;
    end else begin
      // Hand preference to the port that lost (or did not ask) this cycle.
      if (gnt0)
        prio <= 1'b1;
      else if (gnt1)
        prio <= 1'b0;

      RVALID0 <= rd0;
      RVALID1 <= rd1;
      if (rd0)
        RDATA0 <= MEM_RD;
      if (rd1)
        RDATA1 <= MEM_RD;
    end
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares one single-port data memory (combinational read, write on CLK rising edge) between two requesters.
- Port 0 is the core load/store unit. Port 1 is the loader/debug master.
- Round-robin arbitration grants one access per cycle. The grant is combinational and the read data is returned registered one cycle later.
- Sits between the requesters and the data memory instance; the memory's A/WE/WD/RD pins connect to the MEM_* ports.

Parameters:
- WIDTH, 32, data width of the memory and requester data buses.
- WIDTH_ADR, 32, address width; passed through to the memory unchanged (the memory decodes the low bits).

Ports:
- CLK  input  1  clock
- RST  input  1  asynchronous reset, active-high
- REQ0  input  1  port 0 access request
- WE0  input  1  port 0 write enable (1 = write, 0 = read)
- A0  input  WIDTH_ADR  port 0 address
- WD0  input  WIDTH  port 0 write data
- GNT0  output  1  port 0 granted this cycle
- RVALID0  output  1  port 0 read data valid
- RDATA0  output  WIDTH  port 0 read data
- REQ1, WE1, A1, WD1, GNT1, RVALID1, RDATA1: same as port 0, for port 1
- MEM_A  output  WIDTH_ADR  memory address
- MEM_WE  output  1  memory write enable
- MEM_WD  output  WIDTH  memory write data
- MEM_RD  input  WIDTH  memory read data (combinational from MEM_A)

Behaviour:
- State:
  - PRIO: 1-bit round-robin pointer naming the preferred port.
  - RVALID0/1 and RDATA0/1 registers.
- Reset (async, RST=1):
  - PRIO=0.
  - RVALID0=RVALID1=0.
  - RDATA0=RDATA1=0.
  - GNT0/GNT1 and MEM_WE evaluate to 0 while no REQ is asserted.
- Grant (combinational, same cycle):
  - Only one request asserted → that port is granted.
  - Both requests asserted → port PRIO is granted.
  - No request → no grant.
  - GNT0 and GNT1 are never both 1.
- Memory drive:
  - MEM_A, MEM_WE, MEM_WD come from the granted port.
  - No grant → MEM_A=A0, MEM_WD=WD0, MEM_WE=0.
  - MEM_WE = granted port's WE AND its REQ. A stray WE without REQ never writes.
- Pointer update at posedge:
  - If a grant occurred, PRIO <= non-granted port index.
  - Otherwise PRIO holds.
  - Effect: a requester held off in cycle N is guaranteed to be granted in cycle N+1 if it keeps REQ high. Worst-case wait is 1 cycle.
- Handshake:
  - A requester keeps REQ, WE, A and WD stable until it sees its GNT.
  - The transfer completes in the cycle where REQ=1 and GNT=1.
  - Back-to-back grants to one port are allowed when the other port is idle.
- Read response:
  - On a granted read (WE=0) at posedge: RDATAx <= MEM_RD and RVALIDx <= 1.
  - RVALIDx is a 1-cycle pulse. It is 0 in any cycle not following a granted read of that port.
  - RDATAx holds its last value when RVALIDx=0.
  - Latency from grant to RVALID is 1 cycle.
- Write:
  - The memory commits at the grant posedge.
  - No RVALID is generated for a write.
- Read-after-write:
  - A write granted in cycle N followed by a read of the same address in cycle N+1 (either port) returns the new data.
  - Same-cycle read and write to one address is impossible (single grant).
- Widths: addresses pass through at full width; no truncation or alignment inside this block.
- Reset mid-operation: any pending RVALID is dropped and no response is replayed after RST deasserts.

Test Plan:
- Reset: assert RST with REQ0=REQ1=1 → RVALID0/1=0, PRIO=0. After release, the first simultaneous request grants port 0.
- Single port 0 read: write 0x0000_00AA to addr 3 via port 0 (GNT0=1, MEM_WE=1), then read addr 3 → RVALID0=1 and RDATA0=0x0000_00AA one cycle after the grant; RVALID1 stays 0.
- Contention: REQ0=REQ1=1 (both reads) held for 4 cycles → grants alternate 0,1,0,1; RVALID0/RVALID1 alternate one cycle later with the correct data for A0/A1.
- Read-after-write across ports: port 1 writes 0xDEAD_BEEF to addr 5 in cycle N, port 0 reads addr 5 in cycle N+1 → RDATA0=0xDEAD_BEEF.
- Stray WE: WE1=1 and REQ1=0 with port 0 idle → MEM_WE=0, memory contents unchanged, no GNT.
- Reset during response: granted read at posedge N, RST asserted before posedge N+1 → RVALID0=0 immediately; no RVALID after RST deasserts.
